// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and fixed-point helpers for the MLP linear layer
package mlp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WB, OUT} state_t;

    typedef logic signed [15:0] data_t;

    function automatic longint round_shift(input longint v, input int frac);
        if (frac <= 0) return v;
        return (v + (longint'(1) <<< (frac - 1))) >>> frac;
    endfunction

    function automatic longint sat_narrow(input longint v, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint relu(input longint v);
        return (v < 0) ? 0 : v;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane with synchronous clear
module mac_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = x * w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/mlp_linear_seq.sv
// rtl/mlp_linear_seq.sv - time-multiplexed y = act(round(x*W) + b) with BRAM weight port
module mlp_linear_seq
    import mlp_pkg::*;
#(
    parameter int IN_DIM     = 16,
    parameter int OUT_DIM    = 64,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 40,
    localparam int G         = OUT_DIM / LANES,
    localparam int AW        = (G * IN_DIM > 1) ? $clog2(G * IN_DIM) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*IN_DIM-1:0]  x,
    input  logic                          relu_en,
    output logic                          w_rd_en,
    output logic [AW-1:0]                 w_addr,
    input  logic [DATA_WIDTH*LANES-1:0]   w_rdata,
    input  logic [DATA_WIDTH*OUT_DIM-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*OUT_DIM-1:0] y,
    output logic                          busy
);

    localparam int CW = $clog2(IN_DIM + 1);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    if (OUT_DIM % LANES != 0) begin : g_bad_lanes
        $fatal(1, "OUT_DIM must be a multiple of LANES");
    end
    if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(IN_DIM) || ACC_WIDTH > 64) begin : g_bad_acc
        $fatal(1, "ACC_WIDTH out of range");
    end

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cyc_q;
    logic [GW-1:0]                   g_q;
    logic [AW-1:0]                   addr_q;
    logic [DATA_WIDTH*IN_DIM-1:0]    x_q;
    logic                            relu_q;
    logic [DATA_WIDTH*OUT_DIM-1:0]   y_q;
    logic                            accept, rd_en, mac_en, mac_clr, last_k, last_g;
    logic signed [DATA_WIDTH-1:0]    x_cur;
    logic signed [ACC_WIDTH-1:0]     acc [LANES];
    logic signed [DATA_WIDTH-1:0]    wb_val [LANES];
    int                              base;
    int                              kidx;

    assign accept  = (state_q == IDLE) && in_valid;
    assign rd_en   = (state_q == RUN) && (cyc_q < CW'(IN_DIM));
    // Read data lags the strobe by one cycle, so accumulation runs on cycles 1..IN_DIM.
    assign mac_en  = (state_q == RUN) && (cyc_q != '0);
    assign mac_clr = accept || (state_q == WB);
    assign last_k  = (cyc_q == CW'(IN_DIM));
    assign last_g  = (g_q == GW'(G - 1));

    always_comb begin
        kidx  = mac_en ? int'(cyc_q) - 1 : 0;
        x_cur = x_q[kidx*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (mac_clr),
            .enable(mac_en),
            .x     (x_cur),
            .w     (w_rdata[l*DATA_WIDTH +: DATA_WIDTH]),
            .acc   (acc[l])
        );
    end

    always_comb begin
        longint v;
        v    = 0;
        base = int'(g_q) * LANES;
        for (int l = 0; l < LANES; l++) begin
            v = round_shift(longint'(acc[l]), FRAC_BITS);
            v = v + longint'($signed(b[(base + l)*DATA_WIDTH +: DATA_WIDTH]));
            v = sat_narrow(v, DATA_WIDTH);
            if (relu_q) v = relu(v);
            wb_val[l] = v[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_k) state_d = WB;
            WB:      state_d = last_g ? OUT : RUN;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            g_q    <= '0;
            addr_q <= '0;
            x_q    <= '0;
            relu_q <= 1'b0;
            y_q    <= '0;
        end else begin
            if (accept) begin
                x_q    <= x;
                relu_q <= relu_en;
                g_q    <= '0;
                addr_q <= '0;
                cyc_q  <= '0;
            end
            if (state_q == RUN) cyc_q <= last_k ? '0 : cyc_q + 1'b1;
            if (rd_en) addr_q <= addr_q + 1'b1;
            if (state_q == WB) begin
                for (int l = 0; l < LANES; l++) begin
                    y_q[(base + l)*DATA_WIDTH +: DATA_WIDTH] <= wb_val[l];
                end
                if (!last_g) g_q <= g_q + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign w_rd_en   = rd_en;
    assign w_addr    = rd_en ? addr_q : '0;
    assign y         = y_q;

endmodule

// File: tb/tb_mlp_linear_seq.sv
// tb/tb_mlp_linear_seq.sv - directed self-checking bench for mlp_linear_seq
module tb_mlp_linear_seq;

    localparam int IN_DIM  = 16;
    localparam int OUT_DIM = 64;
    localparam int DW      = 16;
    localparam int LANES   = 4;
    localparam int G       = OUT_DIM / LANES;
    localparam int NW      = G * IN_DIM;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [DW*IN_DIM-1:0]   x = '0;
    logic                   relu_en = 1'b0;
    logic                   w_rd_en;
    logic [7:0]             w_addr;
    logic [DW*LANES-1:0]    w_rdata = '0;
    logic [DW*OUT_DIM-1:0]  b = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [DW*OUT_DIM-1:0]  y;
    logic                   busy;

    logic [DW*LANES-1:0]    wmem [NW];
    logic [15:0]            exp_y [OUT_DIM];
    int                     seen [NW];
    int                     rd_cnt;
    int                     n_vec = 0;
    int                     n_err = 0;

    mlp_linear_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .relu_en  (relu_en),
        .w_rd_en  (w_rd_en),
        .w_addr   (w_addr),
        .w_rdata  (w_rdata),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rdata <= wmem[w_addr];
            seen[w_addr] <= seen[w_addr] + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_w(input logic [15:0] v0, input logic [15:0] vrest);
        for (int a = 0; a < NW; a++) begin
            for (int l = 0; l < LANES; l++) begin
                wmem[a][l*DW +: DW] = ((a % IN_DIM) == 0) ? v0 : vrest;
            end
        end
    endtask

    task automatic fill_x(input logic [15:0] v0, input logic [15:0] vrest);
        for (int k = 0; k < IN_DIM; k++) x[k*DW +: DW] = (k == 0) ? v0 : vrest;
    endtask

    task automatic fill_b(input logic [15:0] v);
        for (int n = 0; n < OUT_DIM; n++) b[n*DW +: DW] = v;
    endtask

    task automatic fill_exp(input logic [15:0] v);
        for (int n = 0; n < OUT_DIM; n++) exp_y[n] = v;
    endtask

    task automatic clear_seen();
        for (int a = 0; a < NW; a++) seen[a] = 0;
        rd_cnt = 0;
    endtask

    task automatic start_and_wait(input logic r, input string tag);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        relu_en  = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        relu_en  = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd288);
    endtask

    task automatic check_y(input string tag);
        for (int n = 0; n < OUT_DIM; n++) begin
            check($sformatf("%s y[%0d]", tag, n), 64'(y[n*DW +: DW]), 64'(exp_y[n]));
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " in_ready after hs"}, 64'(in_ready), 64'd1);
        check({tag, " out_valid after hs"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int bad;
        clear_seen();
        fill_w(16'h0, 16'h0);
        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset w_rd_en", 64'(w_rd_en), 64'd0);
        check("reset y", 64'(y == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic
        fill_x(16'h4000, 16'h0); fill_w(16'h4000, 16'h0); fill_b(16'h1000); fill_exp(16'h3000);
        start_and_wait(1'b0, "basic");
        check_y("basic");
        handshake("basic");

        // saturation negative, ReLU, saturation positive
        fill_x(16'h7FFF, 16'h7FFF); fill_w(16'h8000, 16'h8000); fill_b(16'h0); fill_exp(16'h8000);
        start_and_wait(1'b0, "satneg");
        check_y("satneg");
        handshake("satneg");
        fill_exp(16'h0000);
        start_and_wait(1'b1, "relu");
        check_y("relu");
        handshake("relu");
        fill_w(16'h7FFF, 16'h7FFF); fill_exp(16'h7FFF);
        start_and_wait(1'b0, "satpos");
        check_y("satpos");
        handshake("satpos");

        // rounding
        fill_x(16'h0001, 16'h0); fill_w(16'h4000, 16'h0); fill_exp(16'h0001);
        start_and_wait(1'b0, "rnd_half");
        check_y("rnd_half");
        handshake("rnd_half");
        fill_w(16'h3FFF, 16'h0); fill_exp(16'h0000);
        start_and_wait(1'b0, "rnd_below");
        check_y("rnd_below");
        handshake("rnd_below");
        fill_x(16'hFFFF, 16'h0); fill_w(16'h4000, 16'h0);
        start_and_wait(1'b0, "rnd_neg");
        check_y("rnd_neg");
        handshake("rnd_neg");

        // lane/address mapping, then backpressure on the same token
        fill_x(16'h7FFF, 16'h0); fill_w(16'h0, 16'h0);
        for (int n = 0; n < OUT_DIM; n++) begin
            wmem[(n / LANES) * IN_DIM][(n % LANES)*DW +: DW] = 16'(n << 8);
            exp_y[n] = 16'(n << 8);
        end
        clear_seen();
        start_and_wait(1'b0, "map");
        check_y("map");
        check("map rd count", 64'(rd_cnt), 64'd256);
        bad = 0;
        for (int a = 0; a < NW; a++) if (seen[a] != 1) bad++;
        check("map addr once", 64'(bad), 64'd0);

        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            in_valid = (c == 10);
            x = ~x;
            @(posedge clk);
            #1;
            check($sformatf("bp cyc %0d", c), {61'd0, out_valid, in_ready, 1'b0},
                  {61'd0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_y("bp");
        handshake("bp");
        check("bp busy after hs", 64'(busy), 64'd0);

        // reset mid-run
        fill_x(16'h4000, 16'h0); fill_w(16'h4000, 16'h0); fill_b(16'h1000); fill_exp(16'h3000);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst w_rd_en", 64'(w_rd_en), 64'd0);
        check("rst w_addr", 64'(w_addr), 64'd0);
        check("rst y", 64'(y == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(1'b0, "post_rst");
        check_y("post_rst");
        handshake("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
